// File: rtl/msrv32_dmem_responder.sv
// Data-memory responder for the core's load/store interface: word array with
// byte-lane write masking and a fixed number of wait states per transfer.
module msrv32_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] data_in,
  input  logic [3:0]  wr_mask_in,
  input  logic        wr_req_in,
  input  logic        rd_req_in,
  input  logic [1:0]  htrans_in,
  output logic [31:0] data_out,
  output logic        ready_out,
  output logic        err_out
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state;
  logic [3:0]        wait_cnt;

  logic [IDX_W-1:0]  req_idx;
  logic              req_in_range;
  logic              req_write;
  logic [3:0]        req_mask;
  logic [31:0]       req_data;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [31:0]       offset;
  logic              addr_in_range;
  logic              accept;

  logic              done;
  logic [IDX_W-1:0]  c_idx;
  logic              c_in_range;
  logic              c_write;
  logic [3:0]        c_mask;
  logic [31:0]       c_data;

  assign ready_out     = (state == S_IDLE);
  assign offset        = d_addr_in - BASE_ADDR;
  // 33-bit compare so the span cannot overflow; below-BASE offsets wrap high.
  assign addr_in_range = {1'b0, offset} < SPAN;
  assign accept        = ready_out && (htrans_in == 2'b10) && (wr_req_in || rd_req_in);

  // Completion source: live inputs when there are no wait states, otherwise
  // the request captured at acceptance.
  always_comb begin
    done       = rst_n_in && (state == S_WAIT) && (wait_cnt == 4'd0);
    c_idx      = req_idx;
    c_in_range = req_in_range;
    c_write    = req_write;
    c_mask     = req_mask;
    c_data     = req_data;
    if (WAIT_STATES == 0) begin
      done       = rst_n_in && accept;
      c_idx      = offset[IDX_W+1:2];
      c_in_range = addr_in_range;
      c_write    = wr_req_in;
      c_mask     = wr_mask_in;
      c_data     = data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      data_out <= '0;
      err_out  <= 1'b0;
    end else begin
      err_out <= done && !c_in_range;
      if (done && !c_write) begin
        data_out <= c_in_range ? mem[c_idx] : '0;
      end
      case (state)
        S_IDLE: begin
          if (accept && (WAIT_STATES != 0)) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept) begin
      req_idx      <= offset[IDX_W+1:2];
      req_in_range <= addr_in_range;
      req_write    <= wr_req_in;
      req_mask     <= wr_mask_in;
      req_data     <= data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (done && c_write && c_in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c_mask[i]) begin
          mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, offset[1:0]};

endmodule
